// File: rtl/scan_mux.sv
// Registered N-channel multiplexer with manual select, round-robin auto-scan
// with programmable dwell, and a hold mode that freezes the output.
module scan_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]          sel,
    input  logic [1:0]                mode,
    input  logic [DWELL_W-1:0]        dwell,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          cur_ch,
    output logic                      valid,
    output logic                      wrap,
    output logic                      sel_err
);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'b00,
        ST_SCAN   = 2'b01,
        ST_HOLD   = 2'b10
    } state_t;

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [SEL_W-1:0]     cur_q, cur_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;
    logic                 err_q, err_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;

    logic [DWELL_W-1:0]   dwellLast;
    logic [DWELL_W-1:0]   cntEff;
    logic                 stepNow;
    logic                 selOk;

    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                              input logic [SEL_W-1:0]          ch);
        pick = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch == SEL_W'(k)) pick = bus[k*WIDTH +: WIDTH];
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_MANUAL;
        else        state_q <= state_d;
    end

    // The mode input is the state; reserved encoding behaves as HOLD.
    always_comb begin
        state_d = ST_HOLD;
        unique case (mode)
            2'b00:   state_d = ST_MANUAL;
            2'b01:   state_d = ST_SCAN;
            default: state_d = ST_HOLD;
        endcase
    end

    // Counter restarts at zero whenever SCAN is entered from another state.
    assign dwellLast = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign cntEff    = (state_q == ST_SCAN) ? cnt_q : '0;
    assign stepNow   = (cntEff >= dwellLast);
    assign selOk     = ({1'b0, sel} < CH_LIMIT);

    always_comb begin
        y_d     = y_q;
        cur_d   = cur_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_d)
            ST_MANUAL: begin
                cnt_d = '0;
                if (selOk) begin
                    cur_d   = sel;
                    y_d     = pick(in_bus, sel);
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_SCAN: begin
                y_d     = pick(in_bus, cur_q);
                valid_d = 1'b1;
                if (stepNow) begin
                    cnt_d  = '0;
                    cur_d  = (cur_q == LAST_CH) ? '0 : cur_q + SEL_W'(1);
                    wrap_d = (cur_q == LAST_CH);
                end else begin
                    cnt_d = cntEff + DWELL_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            cur_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            y_q     <= y_d;
            cur_q   <= cur_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y       = y_q;
    assign cur_ch  = cur_q;
    assign valid   = valid_q;
    assign wrap    = wrap_q;
    assign sel_err = err_q;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 4-channel instance for manual/scan/hold/reset
// and a 3-channel instance for the out-of-range select case.
module tb_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] inBusA;
    logic [1:0]  selA, modeA;
    logic [7:0]  dwellA;
    logic [3:0]  yA;
    logic [1:0]  curA;
    logic        validA, wrapA, errA;

    logic [11:0] inBusB;
    logic [1:0]  selB, modeB;
    logic [7:0]  dwellB;
    logic [3:0]  yB;
    logic [1:0]  curB;
    logic        validB, wrapB, errB;

    int errCount   = 0;
    int checkCount = 0;

    logic [3:0] chA [4] = '{4'h0, 4'hA, 4'hF, 4'h9};
    int scanCur [16] = '{0,1,1,2,2,3,3,0,0,1,1,2,2,3,3,0};
    int scanYch [16] = '{0,0,1,1,2,2,3,3,0,0,1,1,2,2,3,3};

    always #5 clk = ~clk;

    scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL_W(8)) dutA (
        .clk(clk), .rst_n(rst_n), .in_bus(inBusA), .sel(selA), .mode(modeA),
        .dwell(dwellA), .y(yA), .cur_ch(curA), .valid(validA), .wrap(wrapA),
        .sel_err(errA)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL_W(8)) dutB (
        .clk(clk), .rst_n(rst_n), .in_bus(inBusB), .sel(selB), .mode(modeB),
        .dwell(dwellB), .y(yB), .cur_ch(curB), .valid(validB), .wrap(wrapB),
        .sel_err(errB)
    );

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] s, input logic [7:0] d);
        modeA  = m;
        selA   = s;
        dwellA = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        inBusA = 16'h9FA0;
        inBusB = 12'hC63;
        applyStimulus(2'b00, 2'd0, 8'd2);
        selB   = 2'd0;
        modeB  = 2'b00;
        dwellB = 8'd1;
        #2;
        checkOutput("rst_y", yA, 0);
        checkOutput("rst_cur", curA, 0);
        checkOutput("rst_valid", validA, 0);
        checkOutput("rst_wrap", wrapA, 0);
        checkOutput("rst_err", errA, 0);
        #1 rst_n = 1'b1;

        // Manual walk across all four channels
        for (int s = 0; s < 4; s++) begin
            applyStimulus(2'b00, 2'(s), 8'd2);
            tick();
            checkOutput("man_y", yA, chA[s]);
            checkOutput("man_cur", curA, s);
            checkOutput("man_valid", validA, 1);
            checkOutput("man_err", errA, 0);
            repeat (4) tick();
            checkOutput("man_y_held", yA, chA[s]);
        end

        // Out-of-range select on the 3-channel instance
        selB = 2'd2;
        tick();
        checkOutput("bad_pre_y", yB, 4'hC);
        checkOutput("bad_pre_cur", curB, 2);
        checkOutput("bad_pre_err", errB, 0);
        selB = 2'd3;
        tick();
        checkOutput("bad_err", errB, 1);
        checkOutput("bad_y", yB, 4'hC);
        checkOutput("bad_cur", curB, 2);
        checkOutput("bad_valid", validB, 1);
        tick();
        checkOutput("bad_err_hold", errB, 1);
        selB = 2'd1;
        tick();
        checkOutput("bad_clr_err", errB, 0);
        checkOutput("bad_clr_y", yB, 4'h6);
        checkOutput("bad_clr_cur", curB, 1);
        checkOutput("bad_wrap", wrapB, 0);

        // Scan with dwell 2 starting from channel 0
        applyStimulus(2'b00, 2'd0, 8'd2);
        tick();
        applyStimulus(2'b01, 2'd0, 8'd2);
        for (int n = 0; n < 16; n++) begin
            tick();
            checkOutput("scan2_cur", curA, scanCur[n]);
            checkOutput("scan2_y", yA, chA[scanYch[n]]);
            checkOutput("scan2_wrap", wrapA, (n == 7 || n == 15) ? 1 : 0);
        end

        // Dwell 0 behaves as 1: a step every clock
        applyStimulus(2'b01, 2'd0, 8'd0);
        for (int n = 0; n < 8; n++) begin
            tick();
            checkOutput("scan0_cur", curA, (n + 1) % 4);
            checkOutput("scan0_y", yA, chA[n % 4]);
            checkOutput("scan0_wrap", wrapA, (n % 4 == 3) ? 1 : 0);
        end

        // Hold while channel 2 is on the output, then resume scanning
        applyStimulus(2'b01, 2'd0, 8'd2);
        repeat (5) tick();
        checkOutput("pre_hold_cur", curA, 2);
        checkOutput("pre_hold_y", yA, 4'hF);
        applyStimulus(2'b10, 2'd0, 8'd2);
        tick();
        inBusA = 16'h95A0;
        repeat (3) tick();
        checkOutput("hold_y", yA, 4'hF);
        checkOutput("hold_cur", curA, 2);
        checkOutput("hold_valid", validA, 1);
        checkOutput("hold_wrap", wrapA, 0);
        applyStimulus(2'b01, 2'd0, 8'd2);
        tick();
        checkOutput("resume_y", yA, 4'h5);
        checkOutput("resume_cur", curA, 2);
        tick();
        checkOutput("resume_step", curA, 3);
        tick();
        checkOutput("resume_y3", yA, 4'h9);
        checkOutput("resume_cur3", curA, 3);

        // Reset pulse just before the edge that would wrap 3 -> 0
        rst_n = 1'b0;
        #2;
        checkOutput("mid_rst_y", yA, 0);
        checkOutput("mid_rst_cur", curA, 0);
        checkOutput("mid_rst_valid", validA, 0);
        checkOutput("mid_rst_wrap", wrapA, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_wrap", wrapA, 0);
        checkOutput("post_rst_cur", curA, 0);
        checkOutput("post_rst_valid", validA, 1);
        checkOutput("post_rst_y", yA, 4'h0);
        tick();
        checkOutput("post_rst_step", curA, 1);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Registered N-channel, W-bit multiplexer; parametrised successor to the team's 4:1 × 4-bit combinational mux.
- Adds three operating modes:
  - manual select;
  - auto-scan: round-robin channel stepping with a programmable dwell time;
  - hold: output frozen.
- Adds a 1-cycle registered output, a valid flag, a scan-wrap pulse and a bad-select flag.
- Sits between lab data sources (switch banks, counters) and display/driver logic.

Parameters:
- WIDTH, 4, bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, select width; must satisfy 2^SEL_W >= CHANNELS.
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_bus  input  CHANNELS*WIDTH  packed inputs; channel k = in_bus[k*WIDTH +: WIDTH].
- sel  input  SEL_W  manual channel select.
- mode  input  2  00=MANUAL, 01=SCAN, 10=HOLD, 11=reserved (treated as HOLD).
- dwell  input  DWELL_W  cycles spent on each channel in SCAN; 0 treated as 1.
- y  output  WIDTH  registered selected data.
- cur_ch  output  SEL_W  channel currently driving y.
- valid  output  1  high once y holds sampled channel data.
- wrap  output  1  1-cycle pulse when SCAN steps from channel CHANNELS-1 to 0.
- sel_err  output  1  registered; high while MANUAL and sel >= CHANNELS.

Behaviour:
- Reset (rst_n low, asynchronous):
  - outputs: y=0, cur_ch=0, valid=0, wrap=0, sel_err=0;
  - internal: dwell counter=0, state=MANUAL.
  - Reset asserted mid-scan aborts the scan immediately.
  - On release, operation resumes from channel 0 at the first rising edge.
- State = mode, sampled every clock; a mode change takes effect on the same edge it is sampled.
- MANUAL:
  - If sel < CHANNELS: cur_ch <= sel, y <= channel sel, valid <= 1, sel_err <= 0. Latency: 1 clock from sel/in_bus change to y.
  - If sel >= CHANNELS: cur_ch, y and valid hold their previous values; sel_err <= 1.
  - The dwell counter is cleared in MANUAL.
- SCAN:
  - Each clock: y <= channel cur_ch (live data tracking); valid <= 1; sel_err <= 0.
  - The dwell counter increments each clock. When counter == max(dwell,1)-1:
    - counter <= 0;
    - cur_ch <= cur_ch+1, wrapping from CHANNELS-1 to 0;
    - wrap <= 1 on that wrap edge only, else wrap <= 0.
  - Entering SCAN from another state starts from the current cur_ch with the counter at 0.
  - If dwell changes mid-scan and the counter is already >= new dwell-1, the step happens on the next clock.
  - Because y is registered, y shows the new channel one clock after cur_ch changes.
- HOLD / reserved:
  - y, cur_ch, valid and the counter are frozen.
  - wrap <= 0; sel_err <= 0.
  - in_bus changes are ignored.
- Simultaneous-event rules:
  - wrap is never high outside SCAN.
  - Switching SCAN to MANUAL on the same edge the step would occur: MANUAL wins (cur_ch <= sel, no wrap).
- Arithmetic: the counter is DWELL_W bits and never overflows, because it is cleared at max(dwell,1)-1 <= 2^DWELL_W-2.
- Purely synchronous datapath; no combinational path from inputs to outputs.

Test Plan:
1. Reset and MANUAL walk:
   - Stimulus: CHANNELS=4, WIDTH=4, in_bus ch0..3 = 0000/1010/1111/1001; after reset, sel=0,1,2,3 each held 5 clocks, mode=00.
   - Required response: y = 0000, 1010, 1111, 1001, each 1 clock after sel changes; cur_ch follows; valid rises on the first edge after reset.
2. SCAN with dwell=2 (same data):
   - Required response: cur_ch sequence 0,0,1,1,2,2,3,3,0…
   - wrap pulses exactly on the 3->0 step, once per 8 clocks.
   - y lags cur_ch by 1 clock.
3. dwell=0 in SCAN:
   - Required response: channel steps every clock; wrap every 4 clocks.
4. HOLD:
   - Stimulus: enter mode=10 while cur_ch=2 and y=1111, then change ch2 to 0101.
   - Required response: y stays 1111 and cur_ch stays 2.
   - Stimulus: return to SCAN.
   - Required response: y=0101 next clock, and stepping resumes after dwell cycles.
5. Bad select:
   - Stimulus: CHANNELS=3, sel=3, mode=00.
   - Required response: sel_err=1 next clock; y and cur_ch unchanged.
   - Stimulus: sel=1.
   - Required response: sel_err=0 and y=ch1.
6. Reset mid-scan:
   - Stimulus: pulse rst_n low between clock edges while cur_ch=3 and wrap would fire.
   - Required response: outputs clear immediately without waiting for a clock edge; no wrap pulse; after release with mode=01, the scan restarts at ch0.
